cw305_pulpino_mailbox_ctrl: RTL and testbench



---
 rtl/cw305_mbox_pkg.sv | 45 ++++
 rtl/cw305_mbox_fifo.sv | 50 +++++
 rtl/cw305_pulpino_mailbox_ctrl.sv | 146 ++++++++++++++
 tb/tb_cw305_pulpino_mailbox_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cw305_mbox_pkg.sv
// Shared definitions for the CW305 PULPino mailbox: downlink FSM encoding,
// status-word bit positions and the status packing helper.
package cw305_mbox_pkg;

    localparam int STATUS_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_ACK_LOW = 2'd2
    } mbox_state_e;

    localparam int ST_COUNT_LSB = 0;
    localparam int ST_UP_FULL   = 8;
    localparam int ST_FULL      = 9;
    localparam int ST_EMPTY     = 10;
    localparam int ST_OVF       = 11;
    localparam int ST_UDF       = 12;
    localparam int ST_TMO       = 13;
    localparam int ST_FSM_LSB   = 14;

    function automatic logic [STATUS_W-1:0] pack_status(
        input logic [7:0]  count,
        input logic        up_full,
        input logic        full,
        input logic        empty,
        input logic        ovf,
        input logic        udf,
        input logic        tmo,
        input mbox_state_e state
    );
        logic [STATUS_W-1:0] s;
        s = '0;
        s[ST_COUNT_LSB +: 8] = count;
        s[ST_UP_FULL]        = up_full;
        s[ST_FULL]           = full;
        s[ST_EMPTY]          = empty;
        s[ST_OVF]            = ovf;
        s[ST_UDF]            = udf;
        s[ST_TMO]            = tmo;
        s[ST_FSM_LSB +: 2]   = state;
        return s;
    endfunction

endpackage

// File: rtl/cw305_mbox_fifo.sv
// Synchronous downlink FIFO for the mailbox. The head word is read straight
// out of the register storage, so it is valid in the same cycle it is popped.
module cw305_mbox_fifo #(
    parameter int pDEPTH_LOG2 = 3,
    parameter int pW          = 32
) (
    input  logic                   crypto_clk,
    input  logic                   reset_i,
    input  logic                   push,
    input  logic [pW-1:0]          push_data,
    input  logic                   pop,
    output logic [pW-1:0]          head,
    output logic                   full,
    output logic                   empty,
    output logic [pDEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << pDEPTH_LOG2;

    logic [pW-1:0]          mem [DEPTH];
    logic [pDEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                   do_push, do_pop;

    assign full  = (count == (pDEPTH_LOG2+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a push into a full FIFO
    // alongside a pop is still accepted.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge crypto_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (pDEPTH_LOG2+1)'(do_push) - (pDEPTH_LOG2+1)'(do_pop);
        end
    end

endmodule

// File: rtl/cw305_pulpino_mailbox_ctrl.sv
// Host <-> PULPino word mailbox: downlink FIFO + 4-phase presenter, uplink
// holding register, sticky errors and status word. Optional MBOX_TIMEOUT_EN.
module cw305_pulpino_mailbox_ctrl
    import cw305_mbox_pkg::*;
#(
    parameter int pDEPTH_LOG2 = 3
`ifdef MBOX_TIMEOUT_EN
    ,
    parameter int pTIMEOUT    = 1000,
    parameter int pTO_W       = 16
`endif
) (
    input  logic                crypto_clk,
    input  logic                reset_i,
    input  logic                host_wr_valid,
    input  logic [31:0]         host_wr_data,
    input  logic                host_rd_req,
    output logic [31:0]         host_rd_data,
    input  logic                host_clr,
    output logic                core_rx_valid,
    output logic [31:0]         core_rx_data,
    input  logic                core_rx_ack,
    input  logic                core_tx_valid,
    input  logic [31:0]         core_tx_data,
    output logic                core_tx_ready,
    output logic [STATUS_W-1:0] status
);
    // Handshakes: downlink is 4-phase -- core_rx_valid rises with the word,
    // falls on the edge that sees core_rx_ack=1, and the next word is not
    // offered until ack returns low. Uplink is valid/ready -- a word
    // transfers on any edge where core_tx_valid and core_tx_ready are both 1.

    mbox_state_e           state_q, state_d;
    logic [31:0]           fifo_head;
    logic                  fifo_full, fifo_empty, pop;
    logic [pDEPTH_LOG2:0]  fifo_count;
    logic                  up_full_q;
    logic                  ovf_q, udf_q, tmo_q;
    logic                  ovf_evt, udf_evt;

    cw305_mbox_fifo #(
        .pDEPTH_LOG2 (pDEPTH_LOG2),
        .pW          (32)
    ) u_fifo (
        .crypto_clk (crypto_clk),
        .reset_i    (reset_i),
        .push       (host_wr_valid),
        .push_data  (host_wr_data),
        .pop        (pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    assign pop           = (state_q == ST_IDLE) & ~fifo_empty;
    assign core_rx_valid = (state_q == ST_PRESENT);
    assign core_tx_ready = ~up_full_q;
    assign ovf_evt       = host_wr_valid & fifo_full & ~pop;
    assign udf_evt       = host_rd_req & ~up_full_q;

`ifdef MBOX_TIMEOUT_EN
    logic [pTO_W-1:0] to_cnt_q;
    logic             tmo_evt;
`endif

    always_comb begin
        state_d = state_q;
`ifdef MBOX_TIMEOUT_EN
        tmo_evt = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (core_rx_ack) begin
                    state_d = ST_ACK_LOW;
`ifdef MBOX_TIMEOUT_EN
                end else if (to_cnt_q == pTO_W'(pTIMEOUT - 1)) begin
                    state_d = ST_ACK_LOW;
                    tmo_evt = 1'b1;
`endif
                end
            end
            ST_ACK_LOW: begin
                if (!core_rx_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            core_rx_data <= '0;
        end else begin
            state_q <= state_d;
            if (pop) core_rx_data <= fifo_head;
        end
    end

`ifdef MBOX_TIMEOUT_EN
    // Counts cycles spent in PRESENT; any exit clears it for the next word.
    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            to_cnt_q <= '0;
            tmo_q    <= 1'b0;
        end else begin
            if (state_q == ST_PRESENT && state_d == ST_PRESENT) to_cnt_q <= to_cnt_q + 1'b1;
            else                                              to_cnt_q <= '0;
            tmo_q <= tmo_evt | (tmo_q & ~host_clr);
        end
    end
`else
    assign tmo_q = 1'b0;
`endif

    // A read and a core offer in the same cycle while full: the read wins,
    // and the offer is not taken because ready was low.
    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            up_full_q    <= 1'b0;
            host_rd_data <= '0;
        end else if (host_rd_req && up_full_q) begin
            up_full_q <= 1'b0;
        end else if (core_tx_valid && !up_full_q) begin
            up_full_q    <= 1'b1;
            host_rd_data <= core_tx_data;
        end
    end

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
            status <= '0;
        end else begin
            ovf_q  <= ovf_evt | (ovf_q & ~host_clr);
            udf_q  <= udf_evt | (udf_q & ~host_clr);
            status <= pack_status(8'(fifo_count), up_full_q, fifo_full, fifo_empty,
                                  ovf_q, udf_q, tmo_q, state_q);
        end
    end

endmodule

// File: tb/tb_cw305_pulpino_mailbox_ctrl.sv
// Directed self-checking bench for cw305_pulpino_mailbox_ctrl; the timeout
// section is compiled in only when MBOX_TIMEOUT_EN is defined.
module tb_cw305_pulpino_mailbox_ctrl;

    logic        crypto_clk = 1'b0;
    logic        reset_i;
    logic        host_wr_valid;
    logic [31:0] host_wr_data;
    logic        host_rd_req;
    logic [31:0] host_rd_data;
    logic        host_clr;
    logic        core_rx_valid;
    logic [31:0] core_rx_data;
    logic        core_rx_ack;
    logic        core_tx_valid;
    logic [31:0] core_tx_data;
    logic        core_tx_ready;
    logic [31:0] status;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 crypto_clk = ~crypto_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "watchdog expired");
    end

    cw305_pulpino_mailbox_ctrl #(
        .pDEPTH_LOG2 (3)
`ifdef MBOX_TIMEOUT_EN
        ,
        .pTIMEOUT    (16),
        .pTO_W       (16)
`endif
    ) dut (
        .crypto_clk    (crypto_clk),
        .reset_i       (reset_i),
        .host_wr_valid (host_wr_valid),
        .host_wr_data  (host_wr_data),
        .host_rd_req   (host_rd_req),
        .host_rd_data  (host_rd_data),
        .host_clr      (host_clr),
        .core_rx_valid (core_rx_valid),
        .core_rx_data  (core_rx_data),
        .core_rx_ack   (core_rx_ack),
        .core_tx_valid (core_tx_valid),
        .core_tx_data  (core_tx_data),
        .core_tx_ready (core_tx_ready),
        .status        (status)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge crypto_clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic host_push(input logic [31:0] d, input bit kept);
        host_wr_valid = 1'b1;
        host_wr_data  = d;
        if (kept) exp_q.push_back(d);
        step();
        host_wr_valid = 1'b0;
    endtask

    task automatic host_read();
        host_rd_req = 1'b1;
        step();
        host_rd_req = 1'b0;
    endtask

    task automatic host_clear();
        host_clr = 1'b1;
        step();
        host_clr = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!core_rx_valid && n < 50) begin
            step();
            n++;
        end
        chk(tag, 32'(core_rx_valid), 32'd1);
    endtask

    // Core side: take one presented word, ack two cycles later, then drop ack.
    task automatic core_take(input string tag);
        logic [31:0] exp_w;
        wait_valid({tag, "_valid"});
        exp_w = 32'hxxxx_xxxx;
        if (exp_q.size() > 0) exp_w = exp_q.pop_front();
        chk({tag, "_data"}, core_rx_data, exp_w);
        steps(2);
        chk({tag, "_hold"}, 32'(core_rx_valid), 32'd1);
        core_rx_ack = 1'b1;
        step();
        chk({tag, "_drop"}, 32'(core_rx_valid), 32'd0);
        core_rx_ack = 1'b0;
        step();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_i       = 1'b1;
        host_wr_valid = 1'b0;
        host_wr_data  = '0;
        host_rd_req   = 1'b0;
        host_clr      = 1'b0;
        core_rx_ack   = 1'b0;
        core_tx_valid = 1'b0;
        core_tx_data  = '0;
        steps(2);

        chk("rst_valid",   32'(core_rx_valid), 32'd0);
        chk("rst_ready",   32'(core_tx_ready), 32'd1);
        chk("rst_status",  status, 32'h0000_0000);
        chk("rst_rd_data", host_rd_data, 32'h0000_0000);
        chk("rst_rx_data", core_rx_data, 32'h0000_0000);
        reset_i = 1'b0;
        step();
        chk("idle_status", status, 32'h0000_0400);

        // three words in order; one presented, two queued
        host_push(32'hA5A5_0001, 1'b1);
        host_push(32'hA5A5_0002, 1'b1);
        host_push(32'hA5A5_0003, 1'b1);
        step();
        chk("t1_status_q", status, 32'h0000_4002);
        core_take("t1_w1");
        core_take("t1_w2");
        core_take("t1_w3");
        steps(3);
        chk("t1_status_end", status, 32'h0000_0400);

        // ten back-to-back pushes with no ack: nine held, the tenth overflows
        for (int i = 0; i < 10; i++) host_push(32'hB000_0000 + 32'(i), i < 9);
        step();
        chk("t2_full_ovf", status, 32'h0000_4A08);
        chk("t2_presented", core_rx_data, 32'hB000_0000);
        host_clear();
        step();
        chk("t2_clr", status, 32'h0000_4208);
        for (int i = 0; i < 9; i++) core_take("t2_drain");
        steps(3);
        chk("t2_status_end", status, 32'h0000_0400);
        chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // uplink capture, second offer ignored, host read
        core_tx_valid = 1'b1;
        core_tx_data  = 32'hDEAD_BEEF;
        step();
        chk("t3_ready_low", 32'(core_tx_ready), 32'd0);
        core_tx_data = 32'h1234_5678;
        steps(2);
        chk("t3_up_full", status, 32'h0000_0500);
        core_tx_valid = 1'b0;
        host_read();
        chk("t3_rd_data", host_rd_data, 32'hDEAD_BEEF);
        chk("t3_ready_hi", 32'(core_tx_ready), 32'd1);
        step();
        chk("t3_status", status, 32'h0000_0400);

        // read while empty -> udf; clear in the same cycle as a new udf keeps it
        host_read();
        step();
        chk("t4_udf", status, 32'h0000_1400);
        chk("t4_rd_keep", host_rd_data, 32'hDEAD_BEEF);
        host_rd_req = 1'b1;
        host_clr    = 1'b1;
        step();
        host_rd_req = 1'b0;
        host_clr    = 1'b0;
        step();
        chk("t4_clr_vs_evt", status, 32'h0000_1400);
        host_clear();
        step();
        chk("t4_clr", status, 32'h0000_0400);

        // read and core offer together while full: read wins, offer refused
        core_tx_valid = 1'b1;
        core_tx_data  = 32'h1111_2222;
        step();
        core_tx_data  = 32'h3333_4444;
        host_rd_req   = 1'b1;
        step();
        host_rd_req   = 1'b0;
        core_tx_valid = 1'b0;
        chk("t5_ready", 32'(core_tx_ready), 32'd1);
        chk("t5_rd_data", host_rd_data, 32'h1111_2222);
        step();
        chk("t5_status", status, 32'h0000_0400);

`ifdef MBOX_TIMEOUT_EN
        // no ack: valid must last exactly 16 cycles, then the next word waits for ack low
        begin
            int n;
            host_push(32'hF00D_0001, 1'b0);
            wait_valid("t6_valid");
            n = 0;
            while (core_rx_valid && n < 40) begin
                n++;
                step();
            end
            chk("t6_valid_cycles", 32'(n), 32'd16);
            core_rx_ack = 1'b1;
            host_push(32'hF00D_0002, 1'b1);
            step();
            chk("t6_tmo_status", status, 32'h0000_A001);
            steps(3);
            chk("t6_wait_ack_low", 32'(core_rx_valid), 32'd0);
            core_rx_ack = 1'b0;
            core_take("t6_next");
            host_clear();
            steps(2);
            chk("t6_status_end", status, 32'h0000_0400);
        end
`endif

        // reset while a word is presented and another is queued
        host_push(32'hC0DE_0001, 1'b0);
        host_push(32'hC0DE_0002, 1'b0);
        wait_valid("t7_valid");
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        chk("t7_valid", 32'(core_rx_valid), 32'd0);
        chk("t7_ready", 32'(core_tx_ready), 32'd1);
        chk("t7_rd_data", host_rd_data, 32'h0000_0000);
        step();
        chk("t7_status", status, 32'h0000_0400);
        steps(3);
        chk("t7_discarded", 32'(core_rx_valid), 32'd0);
        chk("t7_status_hold", status, 32'h0000_0400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
